// File: rtl/divider16.sv
// divider16: 16-bit sequential restoring divider, one quotient bit per clock.
// Produces quotient q and remainder r 16 cycles after a start is accepted.
// Optional feature macro: DIVIDER16_SIGNED_EN (two's-complement operands).
// When the macro is undefined, operands and results are unsigned.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start; q/r/div0 hold last result
// RUN   | 16 trial-subtract iterations in progress

module divider16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        start,
    output logic [15:0] q,
    output logic [15:0] r,
    output logic        busy,
    output logic        done,
    output logic        div0
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic        r_state;
    // Dividend shifts out at the top while quotient bits shift in at the bottom,
    // so after 16 iterations this register holds the quotient.
    logic [15:0] r_dividend;
    logic [15:0] r_divisor;
    logic [16:0] r_rem;
    logic [4:0]  r_cnt;
    logic [15:0] r_q;
    logic [15:0] r_r;
    logic        r_done;
    logic        r_div0;
`ifdef DIVIDER16_SIGNED_EN
    logic        r_qneg;
    logic        r_rneg;
`endif

    logic [15:0] w_x_mag;
    logic [15:0] w_y_mag;
    logic [16:0] w_rem_sh;
    logic        w_ge;
    logic [16:0] w_rem_nx;
    logic [15:0] w_quo_nx;
    logic [15:0] w_q_fin;
    logic [15:0] w_r_fin;
    logic        w_last;

    // Operand magnitudes captured on start (identity in the unsigned build).
    always_comb begin
`ifdef DIVIDER16_SIGNED_EN
        w_x_mag = x[15] ? (16'd0 - x) : x;
        w_y_mag = y[15] ? (16'd0 - y) : y;
`else
        w_x_mag = x;
        w_y_mag = y;
`endif
    end

    // One restoring iteration: shift, trial compare, conditional subtract.
    always_comb begin
        w_rem_sh = {r_rem[15:0], r_dividend[15]};
        w_ge     = (w_rem_sh >= {1'b0, r_divisor});
        w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_divisor}) : w_rem_sh;
        w_quo_nx = {r_dividend[14:0], w_ge};
        w_last   = (r_cnt == 5'd15);
    end

    // Sign correction applied on the completing edge so latency is unchanged.
    always_comb begin
`ifdef DIVIDER16_SIGNED_EN
        w_q_fin = r_qneg ? (16'd0 - w_quo_nx) : w_quo_nx;
        w_r_fin = r_rneg ? (16'd0 - w_rem_nx[15:0]) : w_rem_nx[15:0];
`else
        w_q_fin = w_quo_nx;
        w_r_fin = w_rem_nx[15:0];
`endif
    end

    // Control FSM, datapath registers and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_dividend <= 16'd0;
            r_divisor  <= 16'd0;
            r_rem      <= 17'd0;
            r_cnt      <= 5'd0;
            r_q        <= 16'd0;
            r_r        <= 16'd0;
            r_done     <= 1'b0;
            r_div0     <= 1'b0;
`ifdef DIVIDER16_SIGNED_EN
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dividend <= w_x_mag;
                        r_divisor  <= w_y_mag;
                        r_rem      <= 17'd0;
                        r_cnt      <= 5'd0;
`ifdef DIVIDER16_SIGNED_EN
                        r_qneg     <= x[15] ^ y[15];
                        r_rneg     <= x[15];
`endif
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_dividend <= w_quo_nx;
                    r_rem      <= w_rem_nx;
                    r_cnt      <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_q     <= w_q_fin;
                        r_r     <= w_r_fin;
                        r_div0  <= (r_divisor == 16'd0);
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign q    = r_q;
    assign r    = r_r;
    assign div0 = r_div0;
    assign done = r_done;
    assign busy = (r_state == S_RUN);

endmodule

// File: tb/tb_divider16.sv
// tb_divider16: directed-vector bench for divider16 with hand-computed results.
// Signed vectors are included when DIVIDER16_SIGNED_EN is defined.

module tb_divider16;

    logic        clk;
    logic        rst;
    logic [15:0] x;
    logic [15:0] y;
    logic        start;
    logic [15:0] q;
    logic [15:0] r;
    logic        busy;
    logic        done;
    logic        div0;

    int total;
    int bad;

    divider16 dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .y     (y),
        .start (start),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .div0  (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive operands and start, return just after the accepting edge.
    task automatic start_op(input logic [15:0] xv, input logic [15:0] yv);
        x     = xv;
        y     = yv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    // Wait for done (bounded), check latency and results.
    task automatic wait_done(input int lat, input string tag,
                             input logic [15:0] eq, input logic [15:0] er, input logic ed0);
        int got_lat;
        got_lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got_lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, got_lat, lat);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_r"}, r, er);
        chk({tag, "_div0"}, div0, ed0);
        chk({tag, "_busy_clear"}, busy, 1'b0);
    endtask

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (!rst) chk("busy_done_excl", busy & done, 1'b0);
    end

    initial begin
        int ndone;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        x     = 16'd0;
        y     = 16'd0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_q", q, 16'd0);
        chk("rst_r", r, 16'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_div0", div0, 1'b0);

        start_op(16'd1000, 16'd7);
        wait_done(16, "d1000_7", 16'd142, 16'd6, 1'b0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 1'b0);
        chk("q_held", q, 16'd142);

        start_op(16'hFFFF, 16'd1);
        wait_done(16, "dffff_1", 16'hFFFF, 16'd0, 1'b0);

        start_op(16'd3, 16'h0010);
        wait_done(16, "d3_16", 16'd0, 16'd3, 1'b0);

        start_op(16'd5, 16'd0);
        wait_done(16, "d5_0", 16'hFFFF, 16'd5, 1'b1);

        start_op(16'd9, 16'd3);
        wait_done(16, "d9_3", 16'd3, 16'd0, 1'b0);

        // Start pulsed mid-run must be ignored.
        start_op(16'd100, 16'd9);
        repeat (4) @(posedge clk);
        #1;
        x     = 16'd1;
        y     = 16'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(11, "d100_9_ignore", 16'd11, 16'd1, 1'b0);

        // Back-to-back: start in the done cycle.
        start_op(16'd20, 16'd6);
        wait_done(16, "d20_6_b2b", 16'd3, 16'd2, 1'b0);

        // Reset mid-run aborts with no done pulse.
        start_op(16'd50, 16'd7);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_q", q, 16'd0);
        chk("abort_r", r, 16'd0);
        chk("abort_div0", div0, 1'b0);
        chk("abort_done", done, 1'b0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        start_op(16'd1000, 16'd7);
        wait_done(16, "after_abort", 16'd142, 16'd6, 1'b0);

`ifdef DIVIDER16_SIGNED_EN
        start_op(16'hFFF9, 16'd2);
        wait_done(16, "s_m7_2", 16'hFFFD, 16'hFFFF, 1'b0);
        start_op(16'd7, 16'hFFFE);
        wait_done(16, "s_7_m2", 16'hFFFD, 16'd1, 1'b0);
        start_op(16'h8000, 16'hFFFF);
        wait_done(16, "s_min_m1", 16'h8000, 16'd0, 1'b0);
        start_op(16'hFFFB, 16'd0);
        wait_done(16, "s_m5_0", 16'h0001, 16'hFFFB, 1'b1);
        start_op(16'd5, 16'd0);
        wait_done(16, "s_5_0", 16'hFFFF, 16'd5, 1'b1);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
